// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder walks a and b LSB first, one bit per clock,
// and publishes {cout,sum} with a one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;

  always_comb begin
    fa_sum   = a_reg[0] ^ b_reg[0] ^ carry;
    fa_carry = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE accepts start exactly like IDLE so operations can run back to back
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          s_reg <= {fa_sum, s_reg[WIDTH-1:1]};
          carry <= fa_carry;
          // The counter stops at the last bit instead of wrapping
          if (cnt == LAST) begin
            sum   <= {fa_sum, s_reg[WIDTH-1:1]};
            cout  <= fa_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): a table of directed
// additions plus hand-written sequences for hold, reset-abort and back-to-back.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] prev_sum;
  logic             prev_cout;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vc;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  vec_t vecs [12];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with start for one accepting edge, then scrambles the inputs
  task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
    cin   = ~vc;
  endtask

  // Called just after the accepting edge; waits for done within a bounded budget
  task automatic checkOutput(input string nm, input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                             input bit check_pulse);
    int n;
    bit busy_ok;
    bit hold_ok;
    n       = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!done && n < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (sum !== prev_sum || cout !== prev_cout) hold_ok = 1'b0;
      step();
      n++;
    end
    check({nm, " latency"}, n, WIDTH);
    check({nm, " busy"}, {31'd0, busy_ok}, 1);
    check({nm, " hold"}, {31'd0, hold_ok}, 1);
    check({nm, " sum"}, {24'd0, sum}, {24'd0, exp_sum});
    check({nm, " cout"}, {31'd0, cout}, {31'd0, exp_cout});
    prev_sum  = exp_sum;
    prev_cout = exp_cout;
    if (check_pulse) begin
      step();
      check({nm, " pulse"}, {30'd0, done, busy}, 0);
    end
  endtask

  initial begin
    int n;
    bit quiet;

    vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[6]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[7]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[8]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[10] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[11] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    step();
    step();
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset sum", {24'd0, sum}, 0);
    check("reset cout", {31'd0, cout}, 0);
    prev_sum  = '0;
    prev_cout = 1'b0;

    // First start lands on the very first edge with rst low
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vc);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout, 1'b1);
    end

    // start held high throughout, operands zeroed before E3
    a     = 8'h5A;
    b     = 8'h3C;
    cin   = 1'b0;
    start = 1'b1;
    step();
    n = 0;
    while (!done && n < 20) begin
      if (n == 2) begin
        a = '0;
        b = '0;
      end
      step();
      n++;
    end
    check("held latency", n, WIDTH);
    check("held sum", {24'd0, sum}, 32'h96);
    check("held cout", {31'd0, cout}, 0);
    prev_sum  = 8'h96;
    prev_cout = 1'b0;
    step();
    check("held restart busy", {31'd0, busy}, 1);
    check("held restart done", {31'd0, done}, 0);
    start = 1'b0;
    checkOutput("held second", 8'h00, 1'b0, 1'b1);

    // Reset in the middle of an operation aborts it silently
    applyStimulus(8'hFF, 8'h01, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 0);
    check("abort done", {31'd0, done}, 0);
    check("abort sum", {24'd0, sum}, 0);
    check("abort cout", {31'd0, cout}, 0);
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || sum !== '0) quiet = 1'b0;
      step();
    end
    check("abort quiet", {31'd0, quiet}, 1);
    prev_sum  = '0;
    prev_cout = 1'b0;

    // Back-to-back: new start accepted in the DONE cycle
    applyStimulus(8'h5A, 8'h3C, 1'b0);
    checkOutput("b2b first", 8'h96, 1'b0, 1'b0);
    a     = 8'h80;
    b     = 8'h80;
    cin   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = 8'h11;
    b     = 8'h22;
    check("b2b accept busy", {31'd0, busy}, 1);
    checkOutput("b2b second", 8'h00, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal values 2..32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin one addition; sampled on every rising edge.
REQ-005 a  input  WIDTH  operand A; captured only on the edge that accepts start.
REQ-006 b  input  WIDTH  operand B; captured only on the edge that accepts start.
REQ-007 cin  input  1  carry-in; captured only on the edge that accepts start.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 sum  output  WIDTH  registered result of the last completed addition.
REQ-011 cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin using one 1-bit full-adder datapath (sum = x^y^c, carry = majority(x,y,c)), applied to one bit per clock, LSB first.
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-014 IDLE: start=1 -> load the A/B shift registers from a and b, load the carry flop from cin, clear the bit counter, and go to SHIFT; start=0 -> stay in IDLE.
REQ-015 SHIFT: on each edge, feed the A/B register LSBs and the carry flop to the full adder, shift A/B right by one, shift the sum bit into the MSB of the internal sum register, update the carry flop, and increment the counter.
REQ-016 SHIFT: on the edge that processes bit WIDTH-1, go to DONE and copy the complete internal sum and final carry into the sum and cout output registers.
REQ-017 DONE: start=1 -> behave exactly as the IDLE start acceptance (back-to-back operation); start=0 -> go to IDLE.
REQ-018 Latency: if start is accepted at edge E0, SHIFT SHALL occupy edges E1..EWIDTH, and done and the new sum/cout SHALL be visible from EWIDTH to EWIDTH+1.
REQ-019 busy SHALL be 1 exactly while the state is SHIFT; done SHALL be 1 exactly while the state is DONE.
REQ-020 start asserted while in SHIFT SHALL be ignored, with no effect on the operands, counter or result.
REQ-021 Changes on a, b or cin after the accepting edge SHALL NOT affect the result in progress.
REQ-022 sum and cout SHALL change only on the completion edge (REQ-016) or on reset, and SHALL hold their value in all other cycles.
REQ-023 The carry-out of bit WIDTH-1 SHALL appear on cout, and the result SHALL wrap modulo 2^WIDTH with no saturation.
REQ-024 The bit counter SHALL be wide enough to count to WIDTH-1 (clog2(WIDTH) bits) and SHALL never wrap during an operation.

Reset
REQ-025 rst=1 at any edge SHALL force the state to IDLE and busy=0, done=0, sum=0, cout=0, and SHALL clear the counter, carry flop and all shift registers.
REQ-026 rst SHALL take priority over start, and an operation interrupted by reset SHALL produce no done pulse and no result update.
REQ-027 The first start after rst deasserts SHALL be accepted on the first edge where rst=0 and start=1.

Verification (WIDTH=8)
REQ-028 a=0x5A, b=0x3C, cin=0, start pulsed at E0 -> busy=1 during E1..E7, done=1 for one cycle after E8, sum=0x96, cout=0.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-030 start held high through the operation, with a and b changed to 0x00 at E3 -> result unaffected (0x5A+0x3C gives 0x96), and one new operation starts from the DONE cycle.
REQ-031 rst=1 at E4 of an operation -> busy=0 and done=0 next cycle, sum/cout=0, and no done pulse follows.
REQ-032 Back-to-back: start=1 in the DONE cycle with a=0x80, b=0x80, cin=0 -> the first result stays valid through DONE, then the second done gives sum=0x00, cout=1, 9 edges after the first done.
